// File: rtl/mmio_uart_bridge.sv
// MMIO peripheral: LED register, synchronised switch port and FIFO-buffered 8N1 UART.
// Optional internal TX->RX loopback register at 0x18 when MMIO_UART_LOOPBACK_EN is defined.
module mmio_uart_bridge #(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  output logic [15:0] led,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF   = 16'(BAUD_DIV / 2);
  localparam logic [7:0] A_LED = 8'h00, A_SW = 8'h04, A_TXD = 8'h08, A_TXS = 8'h0C;
  localparam logic [7:0] A_RXD = 8'h10, A_RXS = 8'h14, A_LOOP = 8'h18;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [15:0] led_q, sw_s1_q, sw_s2_q;
  logic        txovf_q, rxovf_q, ferr_q;
  logic        rx_s1_q, rx_s2_q;
  logic        loop_on, tx_bit;
  logic        unused_ok;

  assign unused_ok = &{1'b0, io_dout[31:16]};

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TXAW-1:0] tx_wp_q, tx_rp_q;
  logic [TXAW:0]   tx_cnt_q;
  logic            tx_empty, tx_full, tx_push, tx_pop, wr_txd;

  assign wr_txd   = io_we && (io_addr == A_TXD);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TXAW+1)'(TX_DEPTH));
  assign tx_push  = wr_txd && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= io_dout[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_bcnt_q, tx_bcnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_idx_q, tx_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_bcnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_idx_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  // Stop-bit expiry pops the next byte directly so back-to-back frames have no idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_idx_d   = tx_idx_q;
    tx_pop     = 1'b0;
    tx_bit     = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rp_q];
          tx_bcnt_d  = DIV_M1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (tx_bcnt_q == '0) begin
          tx_bcnt_d  = DIV_M1;
          tx_idx_d   = '0;
          tx_state_d = S_DATA;
        end else tx_bcnt_d = tx_bcnt_q - 1'b1;
      end
      S_DATA: begin
        tx_bit = tx_sh_q[0];
        if (tx_bcnt_q == '0) begin
          tx_bcnt_d = DIV_M1;
          tx_sh_d   = {1'b0, tx_sh_q[7:1]};
          tx_idx_d  = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
        end else tx_bcnt_d = tx_bcnt_q - 1'b1;
      end
      S_STOP: begin
        if (tx_bcnt_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem_q[tx_rp_q];
            tx_bcnt_d  = DIV_M1;
            tx_state_d = S_START;
          end else tx_state_d = S_IDLE;
        end else tx_bcnt_d = tx_bcnt_q - 1'b1;
      end
    endcase
  end

  // ---------------- loopback option ----------------
`ifdef MMIO_UART_LOOPBACK_EN
  logic loop_q;
  always_ff @(posedge clk) begin
    if (rst) loop_q <= 1'b0;
    else if (io_we && (io_addr == A_LOOP)) loop_q <= io_dout[0];
  end
  assign loop_on = loop_q;
`else
  assign loop_on = 1'b0;
`endif

  assign uart_tx = tx_bit | loop_on;

  // ---------------- RX FSM ----------------
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_bcnt_q, rx_bcnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_brk_q, rx_brk_d;
  logic        rx_push, ferr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_bcnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_idx_q   <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_s1_q    <= loop_on ? tx_bit : uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_idx_q   <= rx_idx_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // After a framing error rx_brk holds IDLE until the line has returned high.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_idx_d   = rx_idx_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_brk_q) begin
          if (rx_s2_q) rx_brk_d = 1'b0;
        end else if (!rx_s2_q) begin
          rx_bcnt_d  = HALF;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_bcnt_q == '0) begin
          rx_bcnt_d  = DIV_M1;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else rx_bcnt_d = rx_bcnt_q - 1'b1;
      end
      S_DATA: begin
        if (rx_bcnt_q == '0) begin
          rx_bcnt_d = DIV_M1;
          rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d  = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
        end else rx_bcnt_d = rx_bcnt_q - 1'b1;
      end
      S_STOP: begin
        if (rx_bcnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (rx_s2_q) rx_push = 1'b1;
          else begin
            ferr_set = 1'b1;
            rx_brk_d = 1'b1;
          end
        end else rx_bcnt_d = rx_bcnt_q - 1'b1;
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RXAW-1:0] rx_wp_q, rx_rp_q;
  logic [RXAW:0]   rx_cnt_q;
  logic            rx_empty, rx_full, rx_pop, rx_acc, rxovf_set;
  logic [31:0]     rx_cnt32;
  logic [3:0]      rx_occ;

  assign rx_empty  = (rx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == (RXAW+1)'(RX_DEPTH));
  assign rx_pop    = io_rd && (io_addr == A_RXD) && !rx_empty;
  assign rx_acc    = rx_push && (!rx_full || rx_pop);
  assign rxovf_set = rx_push && rx_full && !rx_pop;
  assign rx_cnt32  = 32'(rx_cnt_q);
  assign rx_occ    = (rx_cnt32 > 32'd15) ? 4'hF : rx_cnt32[3:0];

  always_ff @(posedge clk) begin
    if (rx_acc) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_acc) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_acc && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_acc && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      txovf_q <= 1'b0;
      rxovf_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      if (io_we && (io_addr == A_LED)) led_q <= io_dout[15:0];
      if (wr_txd && !tx_push) txovf_q <= 1'b1;
      else if (io_we && (io_addr == A_TXS)) txovf_q <= 1'b0;
      // A hardware event in the same cycle as a clearing write wins so it is not lost.
      if (rxovf_set) rxovf_q <= 1'b1;
      else if (io_we && (io_addr == A_RXS)) rxovf_q <= 1'b0;
      if (ferr_set) ferr_q <= 1'b1;
      else if (io_we && (io_addr == A_RXS)) ferr_q <= 1'b0;
    end
  end

  assign led = led_q;

  always_comb begin
    io_din = '0;
    case (io_addr)
      A_LED: io_din = {16'b0, led_q};
      A_SW:  io_din = {16'b0, sw_s2_q};
      A_TXS: io_din = {29'b0, txovf_q, (tx_state_q != S_IDLE) || !tx_empty, !tx_full};
      A_RXD: io_din = rx_empty ? '0 : {24'b0, rx_mem_q[rx_rp_q]};
      A_RXS: io_din = {24'b0, rx_occ, 1'b0, ferr_q, rxovf_q, !rx_empty};
`ifdef MMIO_UART_LOOPBACK_EN
      A_LOOP: io_din = {31'b0, loop_on};
`endif
      default: io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: a queue/waveform model checked every cycle,
// plus directed literal checks. Exercises loopback when MMIO_UART_LOOPBACK_EN is defined.
module tb_mmio_uart_bridge;
  localparam int BD  = 4;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_dout = '0;
  logic        io_we = 1'b0, io_rd = 1'b0;
  logic [15:0] sw = '0;
  logic        uart_rx = 1'b1;
  logic [31:0] io_din;
  logic [15:0] led;
  logic        uart_tx;

  mmio_uart_bridge #(.BAUD_DIV(BD), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .sw(sw), .led(led), .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- model ----------------
  logic [15:0] led_m, sw1_m, sw2_m;
  logic [7:0]  txq[$];
  logic        wave[$];
  logic [7:0]  rxq[$];
  logic        txovf_m, rxovf_m, ferr_m, loop_m;
  bit          chk_en = 0, rx_chk = 1;
  int          pre_cnt;
  bit          popped;
  logic [7:0]  pb;

  always @(posedge clk) begin
    if (rst) begin
      led_m = '0; sw1_m = '0; sw2_m = '0;
      txq.delete(); wave.delete(); rxq.delete();
      txovf_m = 0; rxovf_m = 0; ferr_m = 0; loop_m = 0;
    end else begin
      if (wave.size() > 0) void'(wave.pop_front());
      pre_cnt = txq.size();
      popped  = 0;
      if (wave.size() == 0 && txq.size() > 0) begin
        pb = txq.pop_front();
        popped = 1;
        repeat (BD) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (BD) wave.push_back(pb[i]);
        repeat (BD) wave.push_back(1'b1);
      end
      if (io_we) begin
        case (io_addr)
          8'h00: led_m = io_dout[15:0];
          8'h08: if (pre_cnt < TXD || popped) txq.push_back(io_dout[7:0]); else txovf_m = 1;
          8'h0C: txovf_m = 0;
          8'h14: begin rxovf_m = 0; ferr_m = 0; end
`ifdef MMIO_UART_LOOPBACK_EN
          8'h18: loop_m = io_dout[0];
`endif
          default: ;
        endcase
      end
      if (io_rd && io_addr == 8'h10 && rxq.size() > 0) void'(rxq.pop_front());
      sw2_m = sw1_m;
      sw1_m = sw;
    end
  end

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int n;
    n = rxq.size();
    case (a)
      8'h00: return {16'h0, led_m};
      8'h04: return {16'h0, sw2_m};
      8'h0C: return {29'b0, txovf_m, (wave.size() > 0 || txq.size() > 0), (txq.size() < TXD)};
      8'h10: return (n > 0) ? {24'b0, rxq[0]} : 32'h0;
      8'h14: return {24'b0, (n > 15) ? 4'hF : 4'(n), 1'b0, ferr_m, rxovf_m, (n > 0)};
`ifdef MMIO_UART_LOOPBACK_EN
      8'h18: return {31'b0, loop_m};
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("uart_tx", 32'(uart_tx), loop_m ? 32'd1 : ((wave.size() > 0) ? 32'(wave[0]) : 32'd1));
      check("led", 32'(led), 32'(led_m));
      if (rx_chk || !(io_addr == 8'h10 || io_addr == 8'h14))
        check("io_din", io_din, exp_read(io_addr));
    end
  end

  // ---------------- drivers (enter/leave 2 ns after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_dout = d; io_we = 1'b1;
    idle(1);
    io_we = 1'b0; io_dout = '0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string nm);
    io_addr = a;
    #1 check(nm, io_din, exp);
  endtask

  task automatic pop(input logic [31:0] exp, input string nm);
    io_addr = 8'h10; io_rd = 1'b1;
    #1 check(nm, io_din, exp);
    idle(1);
    io_rd = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally reads RXDATA on the edge the byte lands.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input bit rd_at_push);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    rx_chk = 0;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      idle(BD);
    end
    uart_rx = 1'b1;
    idle(1);
    if (rd_at_push) begin
      io_addr = 8'h10; io_rd = 1'b1;
      idle(1);
      io_rd = 1'b0;
    end else idle(1);
    idle(2);
    if (stopb) begin
      if (rxq.size() < RXD) rxq.push_back(b); else rxovf_m = 1;
    end else ferr_m = 1;
    rx_chk = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] seq;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1;

    check("reset_led", 32'(led), 32'h0);
    check("reset_tx", 32'(uart_tx), 32'h1);
    peek(8'h0C, 32'h1, "reset_txstat");
    peek(8'h14, 32'h0, "reset_rxstat");
    peek(8'h10, 32'h0, "reset_rxdata");

    wr(8'h00, 32'h0001A5A5);
    check("led_write", 32'(led), 32'h0000A5A5);
    peek(8'h00, 32'h0000A5A5, "led_read");
    wr(8'h20, 32'hFFFFFFFF);
    peek(8'h20, 32'h0, "unmapped_read");
    peek(8'h08, 32'h0, "txdata_read");

    io_addr = 8'h04; sw = 16'h1234;
    #1 check("sw_lat0", io_din, 32'h0);
    idle(1); check("sw_lat1", io_din, 32'h0);
    idle(1); check("sw_lat2", io_din, 32'h1234);

    // single byte 0x55, sampled one cycle into every bit
    seq = 10'b10_1010_1010;
    wr(8'h08, 32'h55);
    idle(2);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("tx55_bit%0d", j), 32'(uart_tx), 32'(seq[j]));
      if (j < 9) idle(4);
    end
    peek(8'h0C, 32'h3, "txstat_in_stop");
    idle(2); peek(8'h0C, 32'h3, "txstat_last_stop");
    idle(1); peek(8'h0C, 32'h1, "txstat_done");

    // TX FIFO overflow while a byte is on the wire
    wr(8'h08, 32'h11);
    idle(2);
    for (int i = 0; i < 9; i++) wr(8'h08, 32'h20 + i);
    peek(8'h0C, 32'h6, "txstat_ovf");
    wr(8'h0C, 32'h0);
    peek(8'h0C, 32'h2, "txstat_ovf_clr");
    idle(400);
    peek(8'h0C, 32'h1, "txstat_drained");

    // RX: good frame, framing error, glitch
    send_frame(8'hC3, 1'b1, 0);
    peek(8'h14, 32'h11, "rxstat_one");
    pop(32'hC3, "rxdata_c3");
    peek(8'h14, 32'h0, "rxstat_empty");
    send_frame(8'h5A, 1'b0, 0);
    peek(8'h14, 32'h04, "rxstat_ferr");
    wr(8'h14, 32'h0);
    peek(8'h14, 32'h0, "rxstat_ferr_clr");
    uart_rx = 1'b0; idle(1); uart_rx = 1'b1;
    idle(12);
    peek(8'h14, 32'h0, "rx_glitch");

    // RX FIFO overflow, then pop and push on the same edge while full
    for (int i = 0; i < 9; i++) send_frame(8'h30 + i, 1'b1, 0);
    peek(8'h14, 32'h83, "rxstat_ovf");
    wr(8'h14, 32'h0);
    peek(8'h14, 32'h81, "rxstat_ovf_clr");
    send_frame(8'hA5, 1'b1, 1);
    peek(8'h14, 32'h81, "rx_pop_push_full");
    peek(8'h10, 32'h31, "rx_head_after");
    for (int i = 0; i < 7; i++) pop(32'h31 + i, "rx_drain");
    pop(32'hA5, "rx_tail");
    peek(8'h14, 32'h0, "rx_drained");

`ifdef MMIO_UART_LOOPBACK_EN
    wr(8'h18, 32'h1);
    peek(8'h18, 32'h1, "loop_read");
    rx_chk = 0;
    wr(8'h08, 32'h7E);
    idle(10 * BD + 12);
    rxq.push_back(8'h7E);
    rx_chk = 1;
    peek(8'h14, 32'h11, "loop_rxstat");
    pop(32'h7E, "loop_rxdata");
    wr(8'h18, 32'h0);
`else
    wr(8'h18, 32'h1);
    peek(8'h18, 32'h0, "loop_absent");
`endif

    // reset mid-frame
    wr(8'h08, 32'h00);
    idle(6);
    rst = 1'b1;
    idle(1);
    check("rst_midframe_tx", 32'(uart_tx), 32'h1);
    check("rst_midframe_led", 32'(led), 32'h0);
    rst = 1'b0;
    peek(8'h0C, 32'h1, "rst_txstat");
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
